// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display path: character codes,
// scan state type and the code-to-segment decode function.
package seg7_pkg;

  localparam int CHAR_W     = 5;
  localparam int NUM_DIGITS = 8;

  // Non-hex character codes; 0x00-0x0F are the hex digits themselves.
  localparam logic [CHAR_W-1:0] CH_BLANK = 5'h10;
  localparam logic [CHAR_W-1:0] CH_DASH  = 5'h11;
  localparam logic [CHAR_W-1:0] CH_U     = 5'h12;
  localparam logic [CHAR_W-1:0] CH_T     = 5'h13;
  localparam logic [CHAR_W-1:0] CH_N     = 5'h14;
  localparam logic [CHAR_W-1:0] CH_R     = 5'h15;
  localparam logic [CHAR_W-1:0] CH_O     = 5'h16;
  localparam logic [CHAR_W-1:0] CH_L     = 5'h17;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  // Returns active-low segments in gfedcba order (bit 0 = segment a).
  // Unused codes fall through to blank.
  function automatic logic [6:0] seg_decode(input logic [CHAR_W-1:0] code);
    logic [6:0] seg;
    case (code)
      5'h00:    seg = 7'h40;
      5'h01:    seg = 7'h79;
      5'h02:    seg = 7'h24;
      5'h03:    seg = 7'h30;
      5'h04:    seg = 7'h19;
      5'h05:    seg = 7'h12;
      5'h06:    seg = 7'h02;
      5'h07:    seg = 7'h78;
      5'h08:    seg = 7'h00;
      5'h09:    seg = 7'h10;
      5'h0A:    seg = 7'h08;
      5'h0B:    seg = 7'h03;
      5'h0C:    seg = 7'h46;
      5'h0D:    seg = 7'h21;
      5'h0E:    seg = 7'h06;
      5'h0F:    seg = 7'h0E;
      CH_DASH:  seg = 7'h3F;
      CH_U:     seg = 7'h41;
      CH_T:     seg = 7'h07;
      CH_N:     seg = 7'h2B;
      CH_R:     seg = 7'h2F;
      CH_O:     seg = 7'h23;
      CH_L:     seg = 7'h47;
      default:  seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational character decoder; thin wrapper so other display logic can
// share the same segment table.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [CHAR_W-1:0] code_i,
  output logic [6:0]        seg_o
);

  assign seg_o = seg_decode(code_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit seven-segment driver. Accepts whole frames over
// valid/ready into a shadow buffer and swaps them into the visible buffer
// only at a scan-frame boundary, so a frame never tears mid-scan. Each digit
// gets a blanking gap before it is lit to suppress ghosting.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int TICK_DIV    = 50_000,
  parameter int BLANK_TICKS = 1,
  parameter int ON_TICKS    = 3,
  parameter int CHAR_W      = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  input  logic [8*CHAR_W-1:0]   frame_data,
  input  logic [7:0]            dp_mask,
  output logic                  frame_start,
  output logic [7:0]            cathodes,
  output logic [7:0]            anodes
);

  if (CHAR_W != seg7_pkg::CHAR_W) begin : g_char_w_guard
    $error("CHAR_W must equal seg7_pkg::CHAR_W");
  end

  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_TICK = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
  localparam int TW       = (MAX_TICK > 1) ? $clog2(MAX_TICK) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] ON_LAST    = TW'(ON_TICKS - 1);

  logic [PW-1:0]              presc_q, presc_d;
  logic [TW-1:0]              tcnt_q, tcnt_d;
  scan_state_e                state_q, state_d;
  logic [2:0]                 digit_q, digit_d;
  logic [7:0][CHAR_W-1:0]     active_q, active_d;
  logic [7:0]                 act_dp_q, act_dp_d;
  logic [7:0][CHAR_W-1:0]     shadow_q, shadow_d;
  logic [7:0]                 sh_dp_q, sh_dp_d;
  logic                       pending_q, pending_d;
  logic [7:0]                 anodes_q, anodes_d;
  logic [7:0]                 cathodes_q, cathodes_d;
  logic                       fs_q, fs_d;

  logic       tick;
  logic       phase_last;
  logic       accept;
  logic       swap;
  logic [6:0] seg_cur;

  assign tick       = en && (presc_q == PRESC_LAST);
  assign phase_last = (state_q == BLANK) ? (tcnt_q == BLANK_LAST) : (tcnt_q == ON_LAST);
  assign accept     = frame_valid && !pending_q;
  // A swap needs pending=1 and an accept needs pending=0, so they are exclusive.
  assign swap       = pending_q &&
                      (!en || (tick && phase_last && state_q == SHOW && digit_q == 3'd7));

  seg7_decode u_decode (
    .code_i (active_q[digit_q]),
    .seg_o  (seg_cur)
  );

  // Prescaler, per-phase tick counter and BLANK/SHOW sequencing per digit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    state_d = state_q;
    digit_d = digit_q;
    if (!en) begin
      presc_d = '0;
      tcnt_d  = '0;
      state_d = BLANK;
      digit_d = 3'd0;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (phase_last) begin
          tcnt_d = '0;
          if (state_q == BLANK) begin
            state_d = SHOW;
          end else begin
            state_d = BLANK;
            digit_d = digit_q + 3'd1;
          end
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    end
  end

  // Frame handshake into the shadow buffer and boundary swap into the active buffer.
  always_comb begin
    shadow_d  = shadow_q;
    sh_dp_d   = sh_dp_q;
    active_d  = active_q;
    act_dp_d  = act_dp_q;
    pending_d = pending_q;
    if (accept) begin
      shadow_d  = frame_data;
      sh_dp_d   = dp_mask;
      pending_d = 1'b1;
    end
    if (swap) begin
      active_d  = shadow_q;
      act_dp_d  = sh_dp_q;
      pending_d = 1'b0;
    end
  end

  // Pin-level outputs derived from the current scan position.
  always_comb begin
    anodes_d   = 8'hFF;
    cathodes_d = 8'hFF;
    fs_d       = en && (state_q == BLANK) && (digit_q == 3'd0) &&
                 (presc_q == '0) && (tcnt_q == '0);
    if (en && state_q == SHOW) begin
      anodes_d   = ~(8'b1 << digit_q);
      cathodes_d = {~act_dp_q[digit_q], seg_cur};
    end
  end

  // Control state, visible frame and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!nrst) begin
      presc_q    <= '0;
      tcnt_q     <= '0;
      state_q    <= BLANK;
      digit_q    <= 3'd0;
      active_q   <= {NUM_DIGITS{CH_BLANK}};
      act_dp_q   <= 8'h00;
      pending_q  <= 1'b0;
      anodes_q   <= 8'hFF;
      cathodes_q <= 8'hFF;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      state_q    <= state_d;
      digit_q    <= digit_d;
      active_q   <= active_d;
      act_dp_q   <= act_dp_d;
      pending_q  <= pending_d;
      anodes_q   <= anodes_d;
      cathodes_q <= cathodes_d;
      fs_q       <= fs_d;
    end
  end

  // Shadow frame storage.
  always_ff @(posedge clk) begin
    // NOTE: the shadow buffer is not reset; it is only read after pending is set, which reset clears.
    shadow_q <= shadow_d;
    sh_dp_q  <= sh_dp_d;
  end

  assign frame_ready = !pending_q;
  assign frame_start = fs_q;
  assign anodes      = anodes_q;
  assign cathodes    = cathodes_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed steps with random frame
// contents, checked every cycle against a scan-time reference model and a
// displayed-frame scoreboard.
module tb_seg7_scan_driver;

  localparam int TICK_DIV    = 4;
  localparam int BLANK_TICKS = 1;
  localparam int ON_TICKS    = 3;
  localparam int CHAR_W      = 5;
  localparam int BLANK_CYC   = TICK_DIV * BLANK_TICKS;
  localparam int DIG_CYC     = TICK_DIV * (BLANK_TICKS + ON_TICKS);
  localparam int SCAN_CYC    = 8 * DIG_CYC;

  // Cathode byte for each code with the decimal point off.
  localparam logic [7:0] CAT_TAB [0:31] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E,
    8'hFF, 8'hBF, 8'hC1, 8'h87, 8'hAB, 8'hAF, 8'hA3, 8'hC7,
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
  };

  logic                 clk = 1'b0;
  logic                 nrst = 1'b0;
  logic                 en = 1'b0;
  logic                 frame_valid = 1'b0;
  logic [8*CHAR_W-1:0]  frame_data = '0;
  logic [7:0]           dp_mask = 8'h00;
  logic                 frame_ready;
  logic                 frame_start;
  logic [7:0]           cathodes;
  logic [7:0]           anodes;

  seg7_scan_driver #(
    .TICK_DIV    (TICK_DIV),
    .BLANK_TICKS (BLANK_TICKS),
    .ON_TICKS    (ON_TICKS),
    .CHAR_W      (CHAR_W)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .en          (en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .dp_mask     (dp_mask),
    .frame_start (frame_start),
    .cathodes    (cathodes),
    .anodes      (anodes)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tb_cat(input logic [4:0] code, input logic dp);
    logic [7:0] c;
    c = CAT_TAB[code];
    if (dp) c[7] = 1'b0;
    return c;
  endfunction

  function automatic logic [63:0] img_of(input logic [39:0] codes, input logic [7:0] dp);
    logic [63:0] img;
    for (int i = 0; i < 8; i++) img[i*8 +: 8] = tb_cat(codes[i*5 +: 5], dp[i]);
    return img;
  endfunction

  function automatic logic [39:0] rand_codes();
    logic [39:0] c;
    for (int i = 0; i < 8; i++) c[i*5 +: 5] = 5'($urandom_range(31, 0));
    return c;
  endfunction

  // ---------------- reference model (scan time since restart) ----------------
  int          m_t;
  int          m_dig;
  int          m_ph;
  bit          m_pend;
  bit          m_pend_pre;
  logic [39:0] m_act;
  logic [7:0]  m_act_dp;
  logic [39:0] m_sh;
  logic [7:0]  m_sh_dp;
  logic [7:0]  e_an;
  logic [7:0]  e_cat;
  logic        e_fs;
  logic        e_ready;
  bit          chk_on = 1'b0;
  logic [63:0] acc_q[$];

  initial forever begin
    @(posedge clk);
    if (!nrst) begin
      m_t      = 0;
      m_act    = {8{5'h10}};
      m_act_dp = 8'h00;
      m_pend   = 1'b0;
      e_an     = 8'hFF;
      e_cat    = 8'hFF;
      e_fs     = 1'b0;
    end else begin
      m_pend_pre = m_pend;
      if (!en) begin
        e_an  = 8'hFF;
        e_cat = 8'hFF;
        e_fs  = 1'b0;
        m_t   = 0;
        if (m_pend_pre) begin
          m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
        end
      end else begin
        m_dig = (m_t / DIG_CYC) % 8;
        m_ph  = m_t % DIG_CYC;
        e_fs  = ((m_t % SCAN_CYC) == 0);
        if (m_ph >= BLANK_CYC) begin
          e_an  = ~(8'h01 << m_dig);
          e_cat = tb_cat(m_act[m_dig*5 +: 5], m_act_dp[m_dig]);
        end else begin
          e_an  = 8'hFF;
          e_cat = 8'hFF;
        end
        if (m_pend_pre && (m_t % SCAN_CYC) == SCAN_CYC - 1) begin
          m_act = m_sh; m_act_dp = m_sh_dp; m_pend = 1'b0;
        end
        m_t++;
      end
      if (frame_valid && !m_pend_pre) begin
        m_sh    = frame_data;
        m_sh_dp = dp_mask;
        m_pend  = 1'b1;
        acc_q.push_back(img_of(frame_data, dp_mask));
      end
    end
    e_ready = !m_pend;
    chk_on  = 1'b1;
  end

  // ---------------- per-cycle checker and displayed-frame scoreboard ----------------
  bit          sb_on = 1'b0;
  logic [63:0] sb_img = '0;
  logic [63:0] sb_last = '0;
  logic [7:0]  sb_mask = 8'h00;
  logic [63:0] seen_q[$];

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("cyc_anodes",      64'(anodes),      64'(e_an));
      check("cyc_cathodes",    64'(cathodes),    64'(e_cat));
      check("cyc_frame_start", 64'(frame_start), 64'(e_fs));
      check("cyc_frame_ready", 64'(frame_ready), 64'(e_ready));
    end
    if (frame_start === 1'b1) begin
      if (sb_on && sb_mask == 8'hFF && sb_img !== sb_last) begin
        seen_q.push_back(sb_img);
        sb_last = sb_img;
      end
      sb_mask = 8'h00;
    end
    for (int d = 0; d < 8; d++) begin
      logic [7:0] one_cold;
      one_cold = ~(8'h01 << d);
      if (anodes === one_cold) begin
        sb_img[d*8 +: 8] = cathodes;
        sb_mask[d]       = 1'b1;
      end
    end
  end

  // ---------------- directed helpers (called at a negedge) ----------------
  task automatic wait_fs(input int max_cyc, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      found = (frame_start === 1'b1);
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic wait_ready(input int max_cyc, input string tag);
    bit found;
    found = (frame_ready === 1'b1);
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      found = (frame_ready === 1'b1);
    end
    check(tag, 64'(found), 64'd1);
  endtask

  task automatic send_frame(input logic [39:0] codes, input logic [7:0] dp,
                            input int max_cyc, input string tag);
    bit found;
    frame_data  = codes;
    dp_mask     = dp;
    frame_valid = 1'b1;
    found = (frame_ready === 1'b1);
    for (int i = 0; i < max_cyc && !found; i++) begin
      @(negedge clk);
      found = (frame_ready === 1'b1);
    end
    @(negedge clk);
    frame_valid = 1'b0;
    check(tag, 64'(found), 64'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  logic [39:0] fr_a, fr_b, fr_c, fr_d, fr_seq;
  logic [7:0]  dp_a, dp_b, dp_c, dp_d, sel;
  int          cyc, n_off, n_on;

  initial begin
    // 1: reset and first scan timing
    en = 1'b1;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_rst_anodes",   64'(anodes),      64'hFF);
    check("t1_rst_cathodes", 64'(cathodes),    64'hFF);
    check("t1_rst_fs",       64'(frame_start), 64'h0);
    nrst = 1'b1;
    wait_fs(4, "t1_fs_after_reset");
    check("t1_ready", 64'(frame_ready), 64'h1);
    repeat (3) @(negedge clk);
    check("t1_still_blank", 64'(anodes), 64'hFF);
    @(negedge clk);
    check("t1_first_anode", 64'(anodes), 64'hFE);

    // 2: load digit i = code i, visible after the scan boundary
    for (int i = 0; i < 8; i++) fr_seq[i*5 +: 5] = 5'(i);
    send_frame(fr_seq, 8'h00, 4, "t2_accept");
    check("t2_ready_low", 64'(frame_ready), 64'h0);
    wait_ready(SCAN_CYC + 8, "t2_ready_high");
    wait_fs(4, "t2_fs");
    repeat (4) @(negedge clk);
    check("t2_dig0_anode",   64'(anodes),   64'hFE);
    check("t2_dig0_cathode", 64'(cathodes), 64'hC0);
    repeat (16) @(negedge clk);
    check("t2_dig1_anode",   64'(anodes),   64'hFD);
    check("t2_dig1_cathode", 64'(cathodes), 64'hF9);

    // 3: blanking gap, lit time and frame period
    wait_fs(SCAN_CYC + 8, "t3_sync");
    cyc = 0;
    for (int d = 0; d < 8; d++) begin
      n_off = 0;
      while (anodes === 8'hFF && n_off < 64) begin n_off++; cyc++; @(negedge clk); end
      check("t3_blank_len", 64'(n_off), 64'(BLANK_CYC));
      sel  = ~(8'h01 << d);
      n_on = 0;
      while (anodes === sel && n_on < 64) begin n_on++; cyc++; @(negedge clk); end
      check("t3_on_len", 64'(n_on), 64'(DIG_CYC - BLANK_CYC));
    end
    check("t3_fs_again",  64'(frame_start), 64'h1);
    check("t3_fs_period", 64'(cyc), 64'd128);

    // 4: back-to-back frames, second held until the first swaps
    wait_ready(SCAN_CYC + 8, "t4_ready");
    fr_a = rand_codes(); dp_a = 8'($urandom);
    fr_b = rand_codes(); dp_b = 8'($urandom);
    acc_q.delete();
    seen_q.delete();
    sb_last = img_of(m_act, m_act_dp);
    sb_on   = 1'b1;
    send_frame(fr_a, dp_a, 4, "t4_accept_a");
    send_frame(fr_b, dp_b, SCAN_CYC + 20, "t4_accept_b");
    wait_ready(SCAN_CYC + 20, "t4_ready_after_b");
    wait_fs(4, "t4_fs_b_start");
    wait_fs(SCAN_CYC + 8, "t4_fs_b_end");
    #1;
    sb_on = 1'b0;
    check("t4_frames_shown", 64'(seen_q.size()), 64'(acc_q.size()));
    for (int i = 0; i < seen_q.size() && i < acc_q.size(); i++)
      check("t4_frame_order", seen_q[i], acc_q[i]);
    if (seen_q.size() >= 2) begin
      check("t4_frame_a", seen_q[0], img_of(fr_a, dp_a));
      check("t4_frame_b", seen_q[1], img_of(fr_b, dp_b));
    end

    // 5: disable mid digit-3 SHOW with a frame pending
    wait_ready(SCAN_CYC + 8, "t5_ready");
    wait_fs(SCAN_CYC + 8, "t5_sync");
    fr_c = rand_codes(); dp_c = 8'($urandom);
    send_frame(fr_c, dp_c, 4, "t5_accept");
    n_on = 0;
    while (anodes !== 8'hF7 && n_on < 100) begin n_on++; @(negedge clk); end
    repeat (5) @(negedge clk);
    check("t5_dig3_lit", 64'(anodes), 64'hF7);
    en = 1'b0;
    @(negedge clk);
    check("t5_off_anodes",   64'(anodes),      64'hFF);
    check("t5_off_cathodes", 64'(cathodes),    64'hFF);
    check("t5_swap_ready",   64'(frame_ready), 64'h1);
    repeat (3) @(negedge clk);
    en = 1'b1;
    wait_fs(4, "t5_fs_restart");
    repeat (4) @(negedge clk);
    check("t5_restart_anode",   64'(anodes),   64'hFE);
    check("t5_restart_cathode", 64'(cathodes), 64'(tb_cat(fr_c[4:0], dp_c[0])));

    // 6: reset mid-scan drops the pending frame
    wait_fs(SCAN_CYC + 8, "t6_sync");
    fr_d = rand_codes(); dp_d = 8'($urandom);
    send_frame(fr_d, dp_d, 4, "t6_accept");
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check("t6_rst_anodes",   64'(anodes),      64'hFF);
    check("t6_rst_cathodes", 64'(cathodes),    64'hFF);
    check("t6_rst_fs",       64'(frame_start), 64'h0);
    check("t6_rst_ready",    64'(frame_ready), 64'h1);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    wait_fs(4, "t6_fs");
    repeat (4) @(negedge clk);
    check("t6_dig0_anode",   64'(anodes),   64'hFE);
    check("t6_dig0_blank",   64'(cathodes), 64'hFF);
    repeat (16) @(negedge clk);
    check("t6_dig1_anode",   64'(anodes),   64'hFD);
    check("t6_dig1_blank",   64'(cathodes), 64'hFF);
    wait_fs(SCAN_CYC + 8, "t6_next_scan");
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
